// File: rtl/control_pkg.sv
// Shared constants for the nic8 sequenced control unit: state codes,
// destination indices and instruction-field position helpers.
package control_pkg;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    localparam int DEST_PC = 0;
    localparam int DEST_A  = 2;

    // IR layout MSB..LSB: {jc, jz, src, dst, indexed}
    function automatic int ir_width(input int src_bits, input int dest_bits);
        return 3 + src_bits + dest_bits;
    endfunction

    function automatic int dst_lsb();
        return 1;
    endfunction

    function automatic int src_lsb(input int dest_bits);
        return dest_bits + 1;
    endfunction

    function automatic int dest_halt(input int dest_bits);
        return (2 ** dest_bits) - 1;
    endfunction

endpackage

// File: rtl/control_seq_onehot_dec.sv
// Binary-to-one-hot decoder with enable; ACTIVE_LOW inverts the whole vector,
// so a disabled active-low decoder drives all ones.
module onehot_dec #(
    parameter int N_BITS     = 2,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [N_BITS-1:0]      sel,
    input  logic                   en,
    output logic [2**N_BITS-1:0]   dec
);

    always_comb begin
        dec = '0;
        if (en) dec[sel] = 1'b1;
        if (ACTIVE_LOW) dec = ~dec;
    end

endmodule

// File: rtl/control_seq.sv
// nic8 control unit: FETCH/EXEC/HALT sequencer with instruction register,
// registered carry/zero flags and combinational decode during EXEC.
module control_seq
    import control_pkg::*;
#(
    parameter int SRC_BITS  = 2,
    parameter int DEST_BITS = 3,
    parameter int DATA_W    = 8,
    parameter int FLAG_DEST = DEST_A
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       bus_in,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    input  logic                    resume,
    output logic                    ir_load,
    output logic                    pc_inc,
    output logic [2**DEST_BITS-1:0] load_en,
    output logic [2**SRC_BITS-1:0]  assert_bar,
    output logic                    immediate,
    output logic                    do_subtract,
    output logic                    do_jump,
    output logic                    flag_c,
    output logic                    flag_z,
    output logic                    halted
);

    localparam int IR_W  = ir_width(SRC_BITS, DEST_BITS);
    localparam int SRC_L = src_lsb(DEST_BITS);
    localparam int DST_L = dst_lsb();
    localparam logic [DEST_BITS-1:0] DST_HALT = DEST_BITS'(dest_halt(DEST_BITS));

    if (DATA_W < IR_W) begin : g_chk_width
        $error("control_seq: DATA_W must be at least IR_W");
    end
    if (FLAG_DEST == DEST_PC || FLAG_DEST >= dest_halt(DEST_BITS)) begin : g_chk_flag
        $error("control_seq: FLAG_DEST must be a non-PC, non-HALT destination");
    end

    logic [1:0]           state;
    logic [1:0]           cur;
    logic [IR_W-1:0]      ir;
    logic                 jc, jz, indexed;
    logic [SRC_BITS-1:0]  src;
    logic [DEST_BITS-1:0] dst;
    logic                 in_exec;
    logic [SRC_BITS-1:0]  src_sel;
    logic                 dest_en;

    assign jc      = ir[IR_W-1];
    assign jz      = ir[IR_W-2];
    assign src     = ir[SRC_L +: SRC_BITS];
    assign dst     = ir[DST_L +: DEST_BITS];
    assign indexed = ir[0];

    // Reset forces FETCH-style outputs in the same cycle it is asserted.
    assign cur     = reset ? FETCH : state;
    assign in_exec = (cur == EXEC);
    assign src_sel = in_exec ? src : '0;
    assign dest_en = in_exec && (dst != DST_HALT);

    onehot_dec #(.N_BITS(DEST_BITS), .ACTIVE_LOW(1'b0)) u_dest_dec (
        .sel (dst),
        .en  (dest_en),
        .dec (load_en)
    );

    onehot_dec #(.N_BITS(SRC_BITS), .ACTIVE_LOW(1'b1)) u_src_dec (
        .sel (src_sel),
        .en  (cur != HALT),
        .dec (assert_bar)
    );

    assign ir_load     = (cur == FETCH);
    assign halted      = (cur == HALT);
    assign immediate   = in_exec & ~indexed;
    assign do_subtract = in_exec & jz;
    assign do_jump     = load_en[DEST_PC] & ((jz & flag_z) | (jc & flag_c) | (jz & jc));
    assign pc_inc      = ir_load | (immediate & ~do_jump);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            ir     <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= bus_in[IR_W-1:0];
                    state <= EXEC;
                end
                EXEC: begin
                    if (load_en[FLAG_DEST]) begin
                        flag_c <= alu_carry;
                        flag_z <= alu_zero;
                    end
                    state <= (dst == DST_HALT) ? HALT : FETCH;
                end
                HALT: begin
                    if (resume) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: reset, loads, immediates, conditional jumps,
// halt/resume and reset during EXEC/HALT, checked with immediate assertions.
module tb_control_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bus_in = 8'hFF;
    logic       alu_carry = 1'b0;
    logic       alu_zero = 1'b0;
    logic       resume = 1'b0;
    logic       ir_load, pc_inc, immediate, do_subtract, do_jump;
    logic       flag_c, flag_z, halted;
    logic [7:0] load_en;
    logic [3:0] assert_bar;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    control_seq dut (
        .clk         (clk),
        .reset       (reset),
        .bus_in      (bus_in),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .resume      (resume),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .load_en     (load_en),
        .assert_bar  (assert_bar),
        .immediate   (immediate),
        .do_subtract (do_subtract),
        .do_jump     (do_jump),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .halted      (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #1;
        // reset, two cycles with garbage on the bus
        settle();
        chk("rst0_ir_load", ir_load, 1);
        chk("rst0_pc_inc", pc_inc, 1);
        chk("rst0_assert_bar", assert_bar, 4'b1110);
        chk("rst0_load_en", load_en, 0);
        tick();
        settle();
        chk("rst1_ir", dut.ir, 0);
        chk("rst1_flags", {flag_c, flag_z}, 0);
        chk("rst1_halted", halted, 0);
        chk("rst1_misc", {immediate, do_subtract, do_jump}, 0);
        tick();
        reset = 1'b0;
        settle();
        chk("post_rst_ir_load", ir_load, 1);
        chk("post_rst_load_en", load_en, 0);

        // load A, carry=1 zero=0
        bus_in = 8'b00_10_010_1;
        tick();
        bus_in = 8'h00; alu_carry = 1'b1; alu_zero = 1'b0;
        settle();
        chk("lda_assert_bar", assert_bar, 4'b1011);
        chk("lda_load_en", load_en, 8'b0000_0100);
        chk("lda_immediate", immediate, 0);
        chk("lda_pc_inc", pc_inc, 0);
        chk("lda_ir_load", ir_load, 0);
        tick();
        alu_carry = 1'b0; alu_zero = 1'b1;
        settle();
        chk("lda_flags", {flag_c, flag_z}, 2'b10);
        chk("lda_back_fetch", ir_load, 1);

        // immediate to dest 3; live ALU values must not touch flags
        bus_in = 8'b00_00_011_0;
        tick();
        settle();
        chk("imm_load_en", load_en, 8'b0000_1000);
        chk("imm_immediate", immediate, 1);
        chk("imm_pc_inc", pc_inc, 1);
        chk("imm_assert_bar", assert_bar, 4'b1110);
        tick();
        settle();
        chk("imm_fetch", ir_load, 1);
        chk("imm_flags_kept", {flag_c, flag_z}, 2'b10);

        // A load with zero=1 -> c=0 z=1
        bus_in = 8'b00_10_010_1;
        tick();
        alu_carry = 1'b0; alu_zero = 1'b1;
        tick();
        settle();
        chk("setz_flags", {flag_c, flag_z}, 2'b01);

        // jz taken
        bus_in = 8'b01_00_000_0;
        tick();
        alu_zero = 1'b0;
        settle();
        chk("jz_t_do_jump", do_jump, 1);
        chk("jz_t_do_subtract", do_subtract, 1);
        chk("jz_t_pc_inc", pc_inc, 0);
        chk("jz_t_load_en", load_en, 8'b0000_0001);
        tick();

        // A load with zero=0 -> flags 00
        bus_in = 8'b00_10_010_1;
        tick();
        alu_carry = 1'b0; alu_zero = 1'b0;
        tick();
        settle();
        chk("clrz_flags", {flag_c, flag_z}, 2'b00);

        // jz not taken even with live alu_zero high
        bus_in = 8'b01_00_000_0;
        tick();
        alu_zero = 1'b1;
        settle();
        chk("jz_n_do_jump", do_jump, 0);
        chk("jz_n_pc_inc", pc_inc, 1);
        chk("jz_n_load_en", load_en, 8'b0000_0001);
        tick();
        alu_zero = 1'b0;

        // unconditional jump (jc & jz) with flags clear
        bus_in = 8'b11_00_000_1;
        tick();
        settle();
        chk("jmp_do_jump", do_jump, 1);
        chk("jmp_pc_inc", pc_inc, 0);
        tick();

        // halt, hold 5 cycles, then resume
        bus_in = 8'b00_00_111_1;
        tick();
        settle();
        chk("hlt_exec_load_en", load_en, 0);
        chk("hlt_exec_halted", halted, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            chk("hlt_halted", halted, 1);
            chk("hlt_strobes", {ir_load, pc_inc, load_en, immediate, do_subtract, do_jump}, 0);
            chk("hlt_assert_bar", assert_bar, 4'b1111);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        settle();
        chk("res_ir_load", ir_load, 1);
        chk("res_halted", halted, 0);

        // reset during EXEC of an A load with carry=1
        bus_in = 8'b00_10_010_1;
        tick();
        reset = 1'b1; alu_carry = 1'b1;
        settle();
        chk("rstx_ir_load", ir_load, 1);
        chk("rstx_load_en", load_en, 0);
        tick();
        reset = 1'b0; alu_carry = 1'b0;
        settle();
        chk("rstx_flag_c", flag_c, 0);
        chk("rstx_state", dut.state, 2'd0);
        chk("rstx_fetch", ir_load, 1);

        // reset together with resume while halted
        bus_in = 8'b00_00_111_1;
        tick();
        tick();
        settle();
        chk("hlt2_halted", halted, 1);
        reset = 1'b1; resume = 1'b1;
        tick();
        reset = 1'b0; resume = 1'b0;
        settle();
        chk("rsth_state", dut.state, 2'd0);
        chk("rsth_ir", dut.ir, 0);
        chk("rsth_halted", halted, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
